// File: rtl/wb_rdwr_arbiter.sv
// wb_rdwr_arbiter: shares one pipelined Wishbone master port between the
// AXI-lite read bridge and write bridge. Ownership is held for the whole
// cyc, ties alternate between ports, and an optional watchdog turns a hung
// slave into an error so neither AXI channel can deadlock.
//
// Handshake: a request is accepted downstream on a clock edge where
// stb is high and stall is low. Each accepted request is answered by
// exactly one ack or err. The arbiter forwards this handshake to the
// current owner. Every non-owner port sees stall=1, ack=0 and err=0.
module wb_rdwr_arbiter #(
    parameter int AW        = 26,
    parameter int DW        = 32,
    parameter int LGTIMEOUT = 10
) (
    input  logic              i_clk,
    input  logic              w_reset,
    // read-bridge port
    input  logic              i_rd_cyc,
    input  logic              i_rd_stb,
    input  logic [AW-1:0]     i_rd_addr,
    output logic              o_rd_ack,
    output logic              o_rd_stall,
    output logic              o_rd_err,
    output logic [DW-1:0]     o_rd_data,
    // write-bridge port
    input  logic              i_wr_cyc,
    input  logic              i_wr_stb,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DW-1:0]     i_wr_data,
    input  logic [DW/8-1:0]   i_wr_sel,
    output logic              o_wr_ack,
    output logic              o_wr_stall,
    output logic              o_wr_err,
    // shared downstream master port
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [AW-1:0]     o_wb_addr,
    output logic [DW-1:0]     o_wb_data,
    output logic [DW/8-1:0]   o_wb_sel,
    input  logic              i_wb_ack,
    input  logic              i_wb_stall,
    input  logic              i_wb_err,
    input  logic [DW-1:0]     i_wb_idata,
    // status: one-hot {wr, rd} owner, doubles as the FSM state view
    output logic [1:0]        o_grant,
    output logic              o_timeout
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_RD   = 2'd1,
        OWN_WR   = 2'd2
    } owner_t;

    owner_t owner_q, owner_d;
    owner_t last_q,  last_d;
    logic   abort_q, abort_d;

    logic   owner_cyc;
    logic   owner_stb;
    logic   is_rd;
    logic   is_wr;
    logic   tmo_hit;

    assign is_rd = (owner_q == OWN_RD);
    assign is_wr = (owner_q == OWN_WR);

    // The owner's request lines; nothing is requested while idle.
    always_comb begin
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        if (is_rd) begin
            owner_cyc = i_rd_cyc;
            owner_stb = i_rd_stb;
        end else if (is_wr) begin
            owner_cyc = i_wr_cyc;
            owner_stb = i_wr_stb;
        end
    end

    // Ownership: hold while the owner's cyc is high, hand over directly on
    // release, and break ties in favour of the port not granted last.
    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        case (owner_q)
            OWN_IDLE: begin
                if (i_rd_cyc && i_wr_cyc)
                    owner_d = (last_q == OWN_RD) ? OWN_WR : OWN_RD;
                else if (i_rd_cyc)
                    owner_d = OWN_RD;
                else if (i_wr_cyc)
                    owner_d = OWN_WR;
                else
                    owner_d = OWN_IDLE;
            end
            OWN_RD: begin
                if (!i_rd_cyc)
                    owner_d = i_wr_cyc ? OWN_WR : OWN_IDLE;
            end
            OWN_WR: begin
                if (!i_wr_cyc)
                    owner_d = i_rd_cyc ? OWN_RD : OWN_IDLE;
            end
            default: owner_d = OWN_IDLE;
        endcase
        if (owner_d != OWN_IDLE)
            last_d = owner_d;
    end

    // Abort latches on a bus error or watchdog hit and is released together
    // with the grant, so late acks from the faulted cycle never leak out.
    always_comb begin
        abort_d = abort_q;
        if (!owner_cyc)
            abort_d = 1'b0;
        else if (tmo_hit || (o_wb_cyc && i_wb_err))
            abort_d = 1'b1;
    end

    // Arbiter state registers.
    always_ff @(posedge i_clk) begin
        if (w_reset) begin
            owner_q <= OWN_IDLE;
            last_q  <= OWN_WR;
            abort_q <= 1'b0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            abort_q <= abort_d;
        end
    end

    generate
        if (LGTIMEOUT > 0) begin : g_wdog
            logic [LGTIMEOUT-1:0] tmo_cnt_q, tmo_cnt_d;

            // Count cycles the bus spends inside cyc without a response.
            always_comb begin
                if (!o_wb_cyc || i_wb_ack || i_wb_err)
                    tmo_cnt_d = '0;
                else
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
            end

            // Watchdog counter register.
            always_ff @(posedge i_clk) begin
                if (w_reset)
                    tmo_cnt_q <= '0;
                else
                    tmo_cnt_q <= tmo_cnt_d;
            end

            assign tmo_hit = o_wb_cyc && !i_wb_ack && !i_wb_err
                             && (tmo_cnt_q == {LGTIMEOUT{1'b1}});
        end else begin : g_no_wdog
            assign tmo_hit = 1'b0;
        end
    endgenerate

    // Downstream request, muxed from the owner; data/sel only for writes.
    assign o_wb_cyc  = owner_cyc && !abort_q;
    assign o_wb_stb  = owner_stb && !abort_q;
    assign o_wb_we   = is_wr;
    assign o_wb_addr = is_wr ? i_wr_addr : (is_rd ? i_rd_addr : '0);
    assign o_wb_data = is_wr ? i_wr_data : '0;
    assign o_wb_sel  = is_wr ? i_wr_sel  : '0;

    // Responses steered to the owner; non-owners are held stalled.
    assign o_rd_ack   = is_rd && i_wb_ack && !abort_q;
    assign o_rd_stall = !is_rd || i_wb_stall || abort_q;
    assign o_rd_err   = is_rd && (i_wb_err || tmo_hit);
    assign o_rd_data  = i_wb_idata;

    assign o_wr_ack   = is_wr && i_wb_ack && !abort_q;
    assign o_wr_stall = !is_wr || i_wb_stall || abort_q;
    assign o_wr_err   = is_wr && (i_wb_err || tmo_hit);

    assign o_grant   = {is_wr, is_rd};
    assign o_timeout = tmo_hit;

endmodule

// File: doc/wb_rdwr_arbiter.md
# wb_rdwr_arbiter

Two-port Wishbone (pipelined) arbiter that shares one downstream Wishbone master port between the AXI-lite read-channel bridge and the AXI-lite write-channel bridge. Together with the two bridges it forms the complete AXI-lite-to-Wishbone slave. It holds ownership for the full duration of a cycle (`cyc`) and alternates priority between the two requesters. An optional bus watchdog converts a hung slave into an error response, so neither AXI channel can deadlock.

## Interface

Parameters:
- AW, 26 — Wishbone word-address width.
- DW, 32 — data width.
- LGTIMEOUT, 10 — log2 of the watchdog limit in cycles; 0 disables the watchdog.

Ports:
- i_clk  in  1  clock.
- w_reset  in  1  reset: synchronous, active-high; clock i_clk.
- i_rd_cyc, i_rd_stb  in  1  read-bridge Wishbone request.
- i_rd_addr  in  AW  read address.
- o_rd_ack, o_rd_stall, o_rd_err  out  1  responses returned to the read bridge.
- o_rd_data  out  DW  read data; equals i_wb_idata.
- i_wr_cyc, i_wr_stb  in  1  write-bridge request.
- i_wr_addr  in  AW  write address.
- i_wr_data  in  DW  write data.
- i_wr_sel  in  DW/8  write byte selects.
- o_wr_ack, o_wr_stall, o_wr_err  out  1  responses returned to the write bridge.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1  downstream request.
- o_wb_addr  out  AW  downstream address.
- o_wb_data  out  DW  downstream write data.
- o_wb_sel  out  DW/8  downstream byte selects.
- i_wb_ack, i_wb_stall, i_wb_err  in  1  downstream responses.
- i_wb_idata  in  DW  downstream read data.
- o_grant  out  2  {wr, rd} one-hot ownership; 00 when idle.
- o_timeout  out  1  one-cycle pulse when the watchdog fires.

## Operation

- State register r_owner ∈ {IDLE, RD, WR}. A separate r_last records the last-granted port and resets to WR, so RD wins the first tie.
- **IDLE:**
  - Only one cyc asserted → go to that port.
  - Both asserted → go to the port ≠ r_last.
  - Neither asserted → stay in IDLE.
- **RD or WR:**
  - Stay while the owner's cyc is high.
  - Owner's cyc low and the other port's cyc high → hand over directly to the other port.
  - Owner's cyc low and the other port's cyc low → go to IDLE.
  - r_last updates on every grant.
- **Downstream outputs:**
  - o_wb_cyc = owner_cyc & !r_abort.
  - o_wb_stb = owner_stb & !r_abort.
  - o_wb_we = (r_owner==WR).
  - addr/data/sel muxed from the owner; o_wb_data and o_wb_sel are 0 when the owner is RD or the state is IDLE.
- **Owner responses:**
  - ack = i_wb_ack & !r_abort.
  - stall = i_wb_stall | r_abort.
  - err = i_wb_err | tmo_hit.
- **Non-owner (and both ports in IDLE):** stall=1, ack=0, err=0.
- **Watchdog (LGTIMEOUT>0):**
  - Counter tmo_cnt (LGTIMEOUT bits) clears when !o_wb_cyc, i_wb_ack or i_wb_err; otherwise it increments.
  - tmo_hit = o_wb_cyc & !i_wb_ack & !i_wb_err & (tmo_cnt == 2^LGTIMEOUT−1).
  - o_timeout = tmo_hit.
- **Abort:**
  - r_abort sets on tmo_hit or (o_wb_cyc & i_wb_err).
  - r_abort clears when the owner's cyc is low, coinciding with the grant release.
  - While r_abort is set, the downstream cyc/stb are forced low and late acks are discarded.

## Timing

- **Reset values:** r_owner=IDLE, r_abort=0, tmo_cnt=0, o_grant=00, o_wb_cyc=o_wb_stb=o_wb_we=0, o_timeout=0, all acks/errs 0, both stalls 1.
- **Arbitration latency:** one cycle. A request raised at edge N (from IDLE) sees stall=1 during cycle N; the grant takes effect at N+1, and stb reaches downstream in the same cycle N+1.
- **Handover latency:** zero idle cycles. The owner drops cyc in cycle N, and the other port owns the bus in cycle N+1.
- All muxed outputs are combinational from the registered r_owner/r_abort.
- **Watchdog timing:** the error reaches the owner in the same cycle as tmo_hit. o_wb_cyc is low from the next cycle.
- **Ack and error in the same cycle:** both are forwarded; the error dominates the abort.
- **Reset mid-transaction:** the state returns to IDLE and o_wb_cyc drops on the next edge; no pending state is kept.

## Test plan

- **Single read:** rd cyc/stb for one cycle, slave acks two cycles after stb, no stall.
  - Required: o_grant=01 one cycle after request, o_wb_we=0, o_rd_ack in the same cycle as i_wb_ack, o_rd_data=i_wb_idata=0xDEADBEEF.
  - Required: IDLE after rd cyc drops.
- **Simultaneous first request:** rd and wr raise cyc on the same edge after reset.
  - Required: RD is granted first and o_wr_stall=1 throughout.
  - Required: on rd release, WR is granted the next cycle with no IDLE cycle; o_wb_we=1, o_wb_sel=i_wr_sel=0xF.
- **Round-robin:** both ports continuously re-request, with 3 transactions each.
  - Required: grants alternate RD, WR, RD, WR, RD, WR.
- **Stall passthrough:** i_wb_stall=1 for 5 cycles during the write owner's stb.
  - Required: o_wr_stall=1 for 5 cycles, with o_wb_addr/data stable.
  - Required: o_rd_stall=1 and o_rd_ack=0 while rd is not granted.
- **Watchdog:** LGTIMEOUT=4, slave never acks.
  - Required: o_timeout and o_wr_err pulse exactly 15 cycles after o_wb_cyc rises, then o_wb_cyc=0.
  - Required: a late i_wb_ack is not forwarded; the grant releases once wr cyc drops.
- **Reset mid-cycle:** w_reset asserted while WR is stalled.
  - Required: next cycle o_grant=00, o_wb_cyc=0, both stalls=1.
